// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port framebuffer between VGA display fetch and a blanking-only host write FIFO
module vga_fb_arbiter #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  pos_x,
    input  logic [9:0]                  pos_y,
    input  logic                        blank_n,
    input  logic                        h_sync_in,
    input  logic                        v_sync_in,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [DATA_W-1:0]           pixel,
    output logic                        pixel_valid,
    output logic                        h_sync,
    output logic                        v_sync,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        addr_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {IDLE, DISP, HOSTWR} acc_t;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] disp_addr;
    logic [LVL_W-1:0]  level_next;
    logic              push, enq, pop, in_range;
    logic [2:0]        h_pipe, v_pipe;
    acc_t              acc_state, rd_state;

    generate
        if (H_ACTIVE == 640) begin : g_shift
            assign disp_addr = (ADDR_W'(pos_y) << 9) + (ADDR_W'(pos_y) << 7) + ADDR_W'(pos_x);
        end else begin : g_mult
            assign disp_addr = ADDR_W'(pos_y) * ADDR_W'(H_ACTIVE) + ADDR_W'(pos_x);
        end
    endgenerate

    // Out-of-range writes complete the handshake but never reach the queue
    assign in_range   = {1'b0, wr_addr} < FB_SIZE;
    assign push       = wr_valid & wr_ready;
    assign enq        = push & in_range;
    assign pop        = ~blank_n & (fifo_level != '0);
    assign level_next = fifo_level + LVL_W'(enq) - LVL_W'(pop);

    // Host write buffer storage; contents need no reset since the level gates them
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    // Queue pointers, level, registered ready and sticky range error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            wr_ready   <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_next;
            wr_ready   <= level_next < LVL_W'(FIFO_DEPTH);
            if (push & ~in_range) addr_err <= 1'b1;
        end
    end

    // Arbitration: display owns the RAM while active, queued writes drain while blanked
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            acc_state <= IDLE;
            rd_state  <= IDLE;
        end else begin
            mem_en    <= blank_n | pop;
            mem_we    <= pop;
            acc_state <= blank_n ? DISP : pop ? HOSTWR : IDLE;
            rd_state  <= acc_state;
            if (blank_n) begin
                mem_addr <= disp_addr;
            end else if (pop) begin
                mem_addr  <= fifo_addr[rd_ptr];
                mem_wdata <= fifo_data[rd_ptr];
            end
        end
    end

    // Returned read data tagged by the access type, syncs delayed to match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel       <= '0;
            pixel_valid <= 1'b0;
            h_pipe      <= '0;
            v_pipe      <= '0;
        end else begin
            pixel       <= (rd_state == DISP) ? mem_rdata : '0;
            pixel_valid <= rd_state == DISP;
            h_pipe      <= {h_pipe[1:0], h_sync_in};
            v_pipe      <= {v_pipe[1:0], v_sync_in};
        end
    end

    assign h_sync = h_pipe[2];
    assign v_sync = v_pipe[2];
endmodule
